dram_read_unpack: RTL and testbench
===================================

# dram_read_unpack

- Sits downstream of the DRAM burst-read controller.
- Captures the 512-bit beats it returns into a FIFO and unpacks them into a valid/ready stream of 32-bit elements, LSB element first.
- Trims the padding at the end of the final beat and flags the last element.
- Exports a burst credit so the upstream controller issues a burst only when the FIFO can absorb every beat of it, because Avalon readdatavalid cannot be back-pressured.

## Interface
Parameters:
- DATAWIDTH, 512, beat width from DRAM
- ELEMWIDTH, 32, output element width; DATAWIDTH/ELEMWIDTH = K (power of two)
- FIFO_LOG, 5, log2 FIFO depth in beats; must be >= MAXBURST_LOG
- MAXBURST_LOG, 4, log2 largest burst in beats
- COUNT_WIDTH, 32, width of the element count

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- START  in  1  one-cycle pulse, begins a transfer
- ELEM_NUM  in  COUNT_WIDTH  elements to deliver; sampled with START
- BUSY  out  1  transfer in progress
- BEAT_DATA  in  DATAWIDTH  beat from DRAM read path
- BEAT_EN  in  1  beat valid; no back-pressure possible
- BURST_ISSUE  in  1  upstream burst accepted this cycle
- BURST_LEN  in  MAXBURST_LOG+1  beats in that burst, 1..2^MAXBURST_LOG
- CREDIT_OK  out  1  room reserved for a maximal burst exists
- OUT_DATA  out  ELEMWIDTH  element
- OUT_VALID  out  1  element valid
- OUT_READY  in  1  consumer accepts
- OUT_LAST  out  1  final element of transfer
- OVERFLOW  out  1  sticky: beat arrived with FIFO full

## Operation
- Two states:
  - IDLE -> RUN on START with ELEM_NUM != 0.
  - RUN -> IDLE on the handshake (OUT_VALID & OUT_READY) of the element with OUT_LAST=1.
  - START with ELEM_NUM=0 stays in IDLE; no output.
  - START while in RUN is ignored.
- On the START that enters RUN:
  - remaining <= ELEM_NUM, idx <= 0.
  - FIFO flushed: occupancy 0, reserved 0.
  - OVERFLOW cleared.
- Credit accounting:
  - `reserved` = beats promised but not yet arrived. Add BURST_LEN on BURST_ISSUE; subtract 1 on BEAT_EN. Both in the same cycle: net BURST_LEN-1.
  - free = 2^FIFO_LOG - occupancy - reserved.
  - CREDIT_OK = (free >= 2^MAXBURST_LOG).
  - Arithmetic in FIFO_LOG+1 bits.
- Beat write: BEAT_EN writes BEAT_DATA when FIFO not full. A write while full is dropped and sets OVERFLOW, which holds until the next START or RST.
- Unpack:
  - OUT_VALID = RUN & FIFO non-empty.
  - OUT_DATA = head[idx*ELEMWIDTH +: ELEMWIDTH]; 0 when OUT_VALID=0.
  - OUT_LAST = OUT_VALID & (remaining == 1).
- On each handshake:
  - remaining decrements and idx increments.
  - The head beat is popped when idx == K-1, or when OUT_LAST; remaining elements of the final beat are discarded, and idx returns to 0.
- Beats arriving in IDLE are written normally. Those left at the end of a transfer are discarded by the next START's flush.
- Simultaneous push and pop at full: both occur, no overflow.

## Timing
- Reset values:
  - BUSY=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, OVERFLOW=0.
  - CREDIT_OK=1, state IDLE, occupancy=reserved=0.
- BUSY=1 the cycle after START (registered state). BUSY=0 the cycle after the last handshake.
- Latency: BEAT_EN at edge n -> OUT_VALID=1 at n+1 if in RUN.
- Throughput: one element per cycle while OUT_READY=1 and the FIFO is non-empty. There are no bubbles at beat boundaries when the next beat is present.
- CREDIT_OK is combinational from registers. BURST_ISSUE updates it one cycle later.
- RST mid-transfer: returns everything to reset values in one cycle; FIFO contents invalid.

## Structure
- Shared package: K, FIFO depth, and the state encoding (IDLE/RUN).
- One sub-module: dram_beat_fifo.
  - Synchronous show-ahead FIFO, DATAWIDTH x 2^FIFO_LOG.
  - Outputs: full, empty, occupancy; supports a flush input.
- Unpack counters, credit logic and FSM live in dram_read_unpack.

## Test plan
- ELEM_NUM=32, two beats holding 1..32 (LSB first), OUT_READY=1 -> outputs 1..32 on consecutive cycles; OUT_LAST only on 32; BUSY falls after.
- ELEM_NUM=20, two beats holding 1..32 -> outputs 1..20 with OUT_LAST on 20; the second beat is popped; FIFO empty.
- OUT_READY toggled 1,0,1,0 during a 16-element transfer -> each element held stable while stalled; none duplicated or lost.
- FIFO_LOG=5: issue BURST_LEN=16 twice without beats -> CREDIT_OK 1,1 then 0. After 16 beats are popped, CREDIT_OK returns to 1.
- 33 beats pushed into a 32-deep FIFO with OUT_READY=0 -> OVERFLOW=1; first 32 beats intact. Next START clears OVERFLOW.
- RST asserted mid-transfer after 5 elements -> next cycle BUSY=0, OUT_VALID=0, CREDIT_OK=1. A new START with ELEM_NUM=16 runs clean.

Source files
------------

// File: rtl/dram_read_unpack_pkg.sv
// Shared definitions for the DRAM read unpacker: default geometry,
// derived beat/element ratio, FIFO depth and the transfer state encoding.
package dram_read_unpack_pkg;

    localparam int DEF_DATAWIDTH    = 512;
    localparam int DEF_ELEMWIDTH    = 32;
    localparam int DEF_FIFO_LOG     = 5;
    localparam int DEF_MAXBURST_LOG = 4;
    localparam int DEF_COUNT_WIDTH  = 32;

    // Elements per beat and beat FIFO depth for the default geometry.
    localparam int K          = DEF_DATAWIDTH / DEF_ELEMWIDTH;
    localparam int FIFO_DEPTH = 2 ** DEF_FIFO_LOG;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of an element index within a beat; never zero so K=1 still elaborates.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/dram_beat_fifo.sv
// Show-ahead beat FIFO: the head beat is visible on rd_data whenever the
// FIFO is non-empty. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; flush empties it without touching storage.
module dram_beat_fifo
    import dram_read_unpack_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int FIFO_LOG  = DEF_FIFO_LOG
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_LOG:0]    occupancy
);

    localparam int DEPTH = 2 ** FIFO_LOG;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [FIFO_LOG-1:0]  wr_ptr;
    logic [FIFO_LOG-1:0]  rd_ptr;
    logic [FIFO_LOG:0]    count;
    logic                 do_push;
    logic                 do_pop;

    assign full      = (count == (FIFO_LOG+1)'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;
    assign rd_data   = mem[rd_ptr];

    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    // Pointer and occupancy bookkeeping; flush behaves like a reset of the bookkeeping only.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Beat storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset; occupancy alone decides which entries are meaningful.
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/dram_read_unpack.sv
// Captures DRAM read beats into a FIFO and unpacks them into a stream of
// elements, LSB element first, trimming the padding of the final beat.
// Also exports a burst credit so upstream never issues a burst the FIFO
// could not absorb (the read-data path cannot be stalled).
module dram_read_unpack
    import dram_read_unpack_pkg::*;
#(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int ELEMWIDTH    = DEF_ELEMWIDTH,
    parameter int FIFO_LOG     = DEF_FIFO_LOG,
    parameter int MAXBURST_LOG = DEF_MAXBURST_LOG,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [COUNT_WIDTH-1:0] ELEM_NUM,
    output logic                   BUSY,
    input  logic [DATAWIDTH-1:0]   BEAT_DATA,
    input  logic                   BEAT_EN,
    input  logic                   BURST_ISSUE,
    input  logic [MAXBURST_LOG:0]  BURST_LEN,
    output logic                   CREDIT_OK,
    output logic [ELEMWIDTH-1:0]   OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OUT_LAST,
    output logic                   OVERFLOW
);

    localparam int ELEMS    = DATAWIDTH / ELEMWIDTH;
    localparam int IDX_W    = idx_width(ELEMS);
    localparam int DEPTH    = 2 ** FIFO_LOG;
    localparam int MAXBURST = 2 ** MAXBURST_LOG;
    localparam int CW       = FIFO_LOG + 1;

    state_t                 state_q;
    state_t                 state_d;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CW-1:0]          reserved_q;
    logic [CW-1:0]          reserved_sum;
    logic [CW-1:0]          reserved_d;
    logic [CW-1:0]          free_beats;
    logic                   overflow_q;

    logic                   start_accept;
    logic                   handshake;
    logic                   is_last;
    logic                   pop_beat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_occ;
    logic [DATAWIDTH-1:0]   head;
    logic [ELEMWIDTH-1:0]   head_elems [ELEMS];

    // A START only counts from IDLE with a non-zero element count.
    assign start_accept = START && (state_q == IDLE) && (ELEM_NUM != '0);

    assign OUT_VALID = (state_q == RUN) && !fifo_empty;
    assign is_last   = OUT_VALID && (remaining_q == COUNT_WIDTH'(1));
    assign handshake = OUT_VALID && OUT_READY;
    // The head beat retires after its top element or after the transfer's final element.
    assign pop_beat  = handshake && ((idx_q == IDX_W'(ELEMS - 1)) || is_last);

    assign BUSY     = (state_q == RUN);
    assign OUT_LAST = is_last;
    assign OVERFLOW = overflow_q;

    dram_beat_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .FIFO_LOG  (FIFO_LOG)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (start_accept),
        .wr_en     (BEAT_EN),
        .wr_data   (BEAT_DATA),
        .rd_en     (pop_beat),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    // Split the head beat into elements, element 0 in the least significant bits.
    always_comb begin
        for (int i = 0; i < ELEMS; i++) begin
            head_elems[i] = head[i*ELEMWIDTH +: ELEMWIDTH];
        end
    end

    // Present the current element, forced to zero when nothing is valid.
    always_comb begin
        OUT_DATA = OUT_VALID ? head_elems[idx_q] : '0;
    end

    // Transfer state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: enter RUN on an accepted START, leave after the last element is taken.
    always_comb begin
        // NOTE: next state defaults to the current one so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_accept)          state_d = RUN;
            RUN:     if (handshake && is_last)  state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Element countdown and position within the head beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            remaining_q <= '0;
            idx_q       <= '0;
        end else if (start_accept) begin
            remaining_q <= ELEM_NUM;
            idx_q       <= '0;
        end else if (handshake) begin
            remaining_q <= remaining_q - 1'b1;
            idx_q       <= pop_beat ? '0 : idx_q + 1'b1;
        end
    end

    // Beats promised by issued bursts but not yet arrived; an unsolicited beat never drives it below zero.
    always_comb begin
        reserved_sum = reserved_q + (BURST_ISSUE ? CW'(BURST_LEN) : '0);
        reserved_d   = (BEAT_EN && (reserved_sum != '0)) ? reserved_sum - 1'b1 : reserved_sum;
    end

    // Reservation register, cleared together with the FIFO on a new transfer.
    always_ff @(posedge CLK) begin
        if (RST || start_accept) reserved_q <= '0;
        else                     reserved_q <= reserved_d;
    end

    // Credit: room left after counting both stored and promised beats.
    assign free_beats = CW'(DEPTH) - fifo_occ - reserved_q;
    assign CREDIT_OK  = (free_beats >= CW'(MAXBURST));

    // Sticky overflow: a beat arrived with the FIFO full and no pop to make room.
    always_ff @(posedge CLK) begin
        if (RST || start_accept) begin
            overflow_q <= 1'b0;
        end else if (BEAT_EN && fifo_full && !pop_beat) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_read_unpack.sv
// Self-checking bench for dram_read_unpack: a per-cycle reference model
// built on a queue of beats and element arithmetic, a table of directed
// transfers, hand-written credit/overflow/reset sequences and random traffic.
module tb_dram_read_unpack;

    localparam int DW     = 512;
    localparam int EW     = 32;
    localparam int K      = DW / EW;
    localparam int DEPTH  = 32;
    localparam int MAXB   = 16;
    localparam int BUDGET = 4000;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [31:0]   ELEM_NUM;
    logic          BUSY;
    logic [DW-1:0] BEAT_DATA;
    logic          BEAT_EN;
    logic          BURST_ISSUE;
    logic [4:0]    BURST_LEN;
    logic          CREDIT_OK;
    logic [EW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          OUT_LAST;
    logic          OVERFLOW;

    always #5 CLK = ~CLK;

    dram_read_unpack dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .ELEM_NUM    (ELEM_NUM),
        .BUSY        (BUSY),
        .BEAT_DATA   (BEAT_DATA),
        .BEAT_EN     (BEAT_EN),
        .BURST_ISSUE (BURST_ISSUE),
        .BURST_LEN   (BURST_LEN),
        .CREDIT_OK   (CREDIT_OK),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_LAST    (OUT_LAST),
        .OVERFLOW    (OVERFLOW)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transfer status, beats held, promised beats, sticky overflow.
    bit            m_run;
    int            m_rem;
    int            m_j;
    int            m_res;
    bit            m_ovf;
    logic [DW-1:0] m_q [$];
    bit            hold_valid;
    logic [EW-1:0] hold_data;

    function automatic void m_reset();
        m_run      = 1'b0;
        m_rem      = 0;
        m_j        = 0;
        m_res      = 0;
        m_ovf      = 1'b0;
        hold_valid = 1'b0;
        m_q.delete();
    endfunction

    function automatic bit m_credit();
        return (DEPTH - m_q.size() - m_res) >= MAXB;
    endfunction

    function automatic logic [DW-1:0] beat_pat(input int b);
        logic [DW-1:0] r;
        for (int w = 0; w < K; w++) r[w*EW +: EW] = EW'(b * K + w + 1);
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_rand();
        logic [DW-1:0] r;
        for (int w = 0; w < K; w++) r[w*EW +: EW] = $urandom;
        return r;
    endfunction

    // One clock cycle: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input bit rst, input bit st, input int elem, input bit ben,
                        input logic [DW-1:0] bdata, input bit iss, input int len, input bit rdy);
        bit            v;
        bit            hs;
        bit            pop;
        bit            room;
        int            sum;
        logic [DW-1:0] h;
        logic [EW-1:0] exp_data;
        v        = m_run && (m_q.size() > 0);
        exp_data = '0;
        if (v) begin
            h        = m_q[0];
            exp_data = h[(m_j % K)*EW +: EW];
        end
        check("busy",      BUSY,      m_run);
        check("out_valid", OUT_VALID, v);
        check("out_data",  OUT_DATA,  exp_data);
        check("out_last",  OUT_LAST,  v && (m_rem == 1));
        check("credit_ok", CREDIT_OK, m_credit());
        check("overflow",  OVERFLOW,  m_ovf);
        if (hold_valid) check("stall_hold", OUT_DATA, hold_data);
        hold_valid = v && !rdy && !rst;
        hold_data  = OUT_DATA;

        RST         = rst;
        START       = st;
        ELEM_NUM    = elem;
        BEAT_EN     = ben;
        BEAT_DATA   = bdata;
        BURST_ISSUE = iss;
        BURST_LEN   = len[4:0];
        OUT_READY   = rdy;

        if (rst) begin
            m_reset();
        end else if (st && !m_run && elem != 0) begin
            m_q.delete();
            m_res = 0;
            m_ovf = 1'b0;
            m_run = 1'b1;
            m_rem = elem;
            m_j   = 0;
        end else begin
            sum = m_res + (iss ? len : 0);
            if (ben && sum > 0) sum--;
            hs   = v && rdy;
            pop  = hs && (((m_j % K) == K - 1) || (m_rem == 1));
            room = (m_q.size() < DEPTH) || pop;
            if (pop) void'(m_q.pop_front());
            if (hs) begin
                m_rem--;
                m_j++;
                if (m_rem == 0) m_run = 1'b0;
            end
            if (ben) begin
                if (room) m_q.push_back(bdata);
                else      m_ovf = 1'b1;
            end
            m_res = sum;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0, rdy);
    endtask

    task automatic do_start(input int elem);
        step(0, 1, elem, 0, '0, 0, 0, 0);
    endtask

    task automatic push_beats(input int first, input int n, input bit pattern);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 1, pattern ? beat_pat(first + i) : beat_rand(), 0, 0, 0);
    endtask

    // Drain the current transfer. mode 0: ready always; 1: ready 1,0,1,0; 2: random traffic.
    task automatic consume(input int extra, input int mode, output logic [EW-1:0] last_data,
                           output int hs_cnt, output int cycles);
        int pushed;
        bit rdy;
        bit ben;
        bit iss;
        bit st;
        pushed    = 0;
        cycles    = 0;
        hs_cnt    = 0;
        last_data = '0;
        while ((m_run || pushed < extra) && cycles < BUDGET) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2) == 0;
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            ben = (pushed < extra) && ($urandom_range(0, 1) == 1);
            if (ben) pushed++;
            iss = (mode == 2) && m_credit() && ($urandom_range(0, 7) == 0);
            st  = (mode == 2) && m_run && ($urandom_range(0, 15) == 0);
            if (OUT_VALID && rdy) begin
                hs_cnt++;
                if (OUT_LAST) last_data = OUT_DATA;
            end
            step(0, st, $urandom_range(1, 40), ben, beat_rand(), iss, $urandom_range(1, 4), rdy);
            cycles++;
        end
        if (cycles >= BUDGET) begin
            checks++;
            failures++;
            $display("FAIL consume_timeout: got busy=%0b after %0d cycles, required completion", BUSY, cycles);
        end
    endtask

    typedef struct {
        int elem;
        int nbeats;
        int mode;
        int exp_left;
        int exp_last;
    } vec_t;

    vec_t          vecs [6];
    logic [EW-1:0] last_data;
    int            hs_cnt;
    int            cycles;
    int            nb;
    int            pre;
    int            elem;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; START = 1'b0; ELEM_NUM = '0; BEAT_EN = 1'b0; BEAT_DATA = '0;
        BURST_ISSUE = 1'b0; BURST_LEN = '0; OUT_READY = 1'b0;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;

        // Reset state.
        check("rst_busy",      BUSY,      0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_last",  OUT_LAST,  0);
        check("rst_out_data",  OUT_DATA,  0);
        check("rst_overflow",  OVERFLOW,  0);
        check("rst_credit_ok", CREDIT_OK, 1);
        idle(2, 0);

        // START with ELEM_NUM=0 stays idle even with a beat waiting.
        push_beats(0, 1, 1);
        do_start(0);
        check("zero_start_busy",  BUSY,      0);
        check("zero_start_valid", OUT_VALID, 0);
        idle(2, 1);

        // Directed transfers: {elem_num, beats, ready mode, beats left, last element}.
        vecs[0] = '{elem: 32, nbeats: 2, mode: 0, exp_left: 0, exp_last: 32};
        vecs[1] = '{elem: 20, nbeats: 2, mode: 0, exp_left: 0, exp_last: 20};
        vecs[2] = '{elem: 16, nbeats: 1, mode: 1, exp_left: 0, exp_last: 16};
        vecs[3] = '{elem: 5,  nbeats: 3, mode: 0, exp_left: 2, exp_last: 5};
        vecs[4] = '{elem: 17, nbeats: 2, mode: 1, exp_left: 0, exp_last: 17};
        vecs[5] = '{elem: 1,  nbeats: 1, mode: 0, exp_left: 0, exp_last: 1};
        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].elem);
            check("vec_busy_after_start", BUSY, 1);
            push_beats(0, vecs[i].nbeats, 1);
            consume(0, vecs[i].mode, last_data, hs_cnt, cycles);
            check("vec_last_data", last_data, vecs[i].exp_last);
            check("vec_handshakes", hs_cnt, vecs[i].elem);
            if (vecs[i].mode == 0) check("vec_no_bubbles", cycles, vecs[i].elem);
            check("vec_busy_done", BUSY, 0);
            check("vec_beats_left", dut.fifo_occ, vecs[i].exp_left);
            idle(1, 0);
        end

        // Credit: two maximal bursts exhaust the reservation; it returns after 16 beats pop.
        do_start(256);
        check("credit_initial", CREDIT_OK, 1);
        step(0, 0, 0, 0, '0, 1, 16, 0);
        check("credit_after_1_issue", CREDIT_OK, 1);
        step(0, 0, 0, 0, '0, 1, 16, 0);
        check("credit_after_2_issues", CREDIT_OK, 0);
        push_beats(0, 32, 1);
        check("credit_fifo_full", CREDIT_OK, 0);
        idle(240, 1);
        check("credit_15_popped", CREDIT_OK, 0);
        idle(16, 1);
        check("credit_16_popped", CREDIT_OK, 1);
        check("credit_busy_done", BUSY, 0);
        idle(1, 0);

        // Overflow: the 33rd beat is dropped, the first 32 drain intact.
        do_start(512);
        push_beats(0, 32, 1);
        check("ovf_before", OVERFLOW, 0);
        push_beats(32, 1, 1);
        check("ovf_after_33", OVERFLOW, 1);
        check("ovf_occ", dut.fifo_occ, 32);
        consume(0, 0, last_data, hs_cnt, cycles);
        check("ovf_last_data", last_data, 512);
        check("ovf_handshakes", hs_cnt, 512);
        check("ovf_sticky", OVERFLOW, 1);
        do_start(16);
        check("ovf_cleared_by_start", OVERFLOW, 0);
        push_beats(0, 1, 1);
        consume(0, 0, last_data, hs_cnt, cycles);
        check("ovf_next_last", last_data, 16);

        // Reset mid-transfer after five elements, then a clean transfer.
        do_start(32);
        push_beats(0, 2, 1);
        idle(5, 1);
        step(1, 0, 0, 0, '0, 0, 0, 0);
        check("midrst_busy",      BUSY,      0);
        check("midrst_out_valid", OUT_VALID, 0);
        check("midrst_credit_ok", CREDIT_OK, 1);
        check("midrst_occ",       dut.fifo_occ, 0);
        idle(1, 0);
        do_start(16);
        push_beats(0, 1, 1);
        consume(0, 0, last_data, hs_cnt, cycles);
        check("midrst_last_data",  last_data, 16);
        check("midrst_handshakes", hs_cnt, 16);

        // Random traffic against the model.
        for (int t = 0; t < 40; t++) begin
            elem = $urandom_range(1, 70);
            nb   = (elem + K - 1) / K + $urandom_range(0, 1);
            pre  = $urandom_range(0, nb);
            do_start(elem);
            push_beats(0, pre, 0);
            consume(nb - pre, 2, last_data, hs_cnt, cycles);
            check("rand_handshakes", hs_cnt, elem);
            idle($urandom_range(0, 2), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
